// File: rtl/lfsr_seq_pkg.sv
// rtl/lfsr_seq_pkg.sv - shared types and constants for the LFSR seed/word sequencer
//
// Contents:
//   seq_state_t  sequencer FSM state encoding
//   LFSR_LEN     core length in stages
//   LOAD_CYCLES  cycles spent shifting a seed into the core
//   seed_bit()   seed bit driven at a given load step, MSB first
package lfsr_seq_pkg;

    localparam int LFSR_LEN    = 3;
    localparam int LOAD_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEEDED = 3'd2,
        GEN    = 3'd3,
        HOLD   = 3'd4
    } seq_state_t;

    // Step 0 drives seed[2], step 1 seed[1], step 2 seed[0].
    function automatic logic seed_bit(input logic [LFSR_LEN-1:0] s,
                                      input logic [1:0]          idx);
        return s[2'(LFSR_LEN - 1) - idx];
    endfunction

endpackage

// File: rtl/lfsr_sequencer_bit_deser.sv
// rtl/lfsr_sequencer_bit_deser.sv - serial-to-parallel word assembler with bit counter
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   shift_en  shift bit_in into the LSB this cycle
//   bit_in    serial input bit
//   data      assembled word, first bit ends up in the MSB
//   done      high on the cycle whose shift completes a word
module bit_deser #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] data,
    output logic              done
);

    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [CW-1:0] cnt;

    assign done = shift_en && (cnt == CW'(WORD_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            data <= {data[WORD_W-2:0], bit_in};
            // Counter wraps on the completing shift so the next word starts clean.
            cnt  <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_sequencer.sv
// rtl/lfsr_sequencer.sv - seeds a 3-stage LFSR core and packs its output into random words
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   seed_valid/seed_ready        seed offer handshake, seed_data[2] shifted first
//   seed_data                    3-bit seed
//   seed_err                     one-cycle pulse when a lock-state seed is refused
//   req                          level request for words
//   word_valid/word_ready        word handshake
//   word_data                    WORD_W-bit word, first sampled bit in MSB
//   lfsr_ena, lfsr_seed          drive the core's ena/seed pins
//   lfsr_out                     core serial output
//   busy                         high in LOAD, GEN and HOLD
module lfsr_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [2:0]        seed_data,
    output logic              seed_err,
    input  logic              req,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              lfsr_ena,
    output logic              lfsr_seed,
    input  logic              lfsr_out,
    output logic              busy
);

    seq_state_t          state;
    logic [1:0]          load_cnt;
    logic [LFSR_LEN-1:0] seed_q;
    logic                deser_done;

    bit_deser #(.WORD_W(WORD_W)) u_deser (
        .clk      (clk),
        .rst      (rst),
        .shift_en (state == GEN),
        .bit_in   (lfsr_out),
        .data     (word_data),
        .done     (deser_done)
    );

    // All outputs are assigned alongside the state they belong to, so each
    // one is registered and always consistent with the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            load_cnt   <= '0;
            seed_q     <= '0;
            seed_ready <= 1'b1;
            seed_err   <= 1'b0;
            word_valid <= 1'b0;
            lfsr_ena   <= 1'b0;
            lfsr_seed  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            seed_err <= 1'b0;
            case (state)
                IDLE, SEEDED: begin
                    if (seed_valid) begin
                        // Seed bits [1:0] land in d2:d1; both zero is the lock state.
                        if (seed_data[1:0] == 2'b00) begin
                            seed_err <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            seed_q     <= seed_data;
                            load_cnt   <= '0;
                            seed_ready <= 1'b0;
                            busy       <= 1'b1;
                            lfsr_ena   <= 1'b0;
                            lfsr_seed  <= seed_bit(seed_data, 2'd0);
                        end
                    end else if (state == SEEDED && req) begin
                        state      <= GEN;
                        seed_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_cnt == 2'(LOAD_CYCLES - 1)) begin
                        lfsr_ena  <= 1'b1;
                        lfsr_seed <= 1'b0;
                        if (req) begin
                            state <= GEN;
                        end else begin
                            state      <= SEEDED;
                            busy       <= 1'b0;
                            seed_ready <= 1'b1;
                        end
                    end else begin
                        load_cnt  <= load_cnt + 2'd1;
                        lfsr_seed <= seed_bit(seed_q, load_cnt + 2'd1);
                    end
                end
                GEN: begin
                    if (deser_done) begin
                        state      <= HOLD;
                        word_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (req) begin
                            state <= GEN;
                        end else begin
                            state      <= SEEDED;
                            busy       <= 1'b0;
                            seed_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    seed_ready <= 1'b1;
                    word_valid <= 1'b0;
                    lfsr_ena   <= 1'b0;
                    lfsr_seed  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_sequencer.sv
// tb/tb_lfsr_sequencer.sv - directed self-checking bench for lfsr_sequencer with a core model
module tb_lfsr_sequencer;

    localparam int WORD_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              seed_valid = 1'b0;
    logic              seed_ready;
    logic [2:0]        seed_data = 3'b000;
    logic              seed_err;
    logic              req = 1'b0;
    logic              word_valid;
    logic              word_ready = 1'b0;
    logic [WORD_W-1:0] word_data;
    logic              lfsr_ena;
    logic              lfsr_seed;
    logic              lfsr_out;
    logic              busy;

    // Core beside the sequencer: seed mux into d1, chain d1->d2->out, taps d1^d2.
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    logic core_out = 1'b0;

    always @(posedge clk) begin
        core_out <= d2;
        d2       <= d1;
        d1       <= lfsr_ena ? (d1 ^ d2) : lfsr_seed;
    end
    assign lfsr_out = core_out;

    always #5 clk = ~clk;

    lfsr_sequencer #(.WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .seed_err   (seed_err),
        .req        (req),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .lfsr_ena   (lfsr_ena),
        .lfsr_seed  (lfsr_seed),
        .lfsr_out   (lfsr_out),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for word_valid; returns number of edges taken.
    task automatic wait_valid(output int n);
        n = 0;
        while (word_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
    endtask

    int   n;
    logic saw_busy;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_seed_ready", 32'(seed_ready), 32'd1);
        chk("rst_seed_err",   32'(seed_err),   32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_data",  32'(word_data),  32'd0);
        chk("rst_lfsr_ena",   32'(lfsr_ena),   32'd0);
        chk("rst_lfsr_seed",  32'(lfsr_seed),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        rst = 1'b1;
        repeat (4) step();

        // Rejected seed in IDLE
        seed_valid = 1'b1;
        seed_data  = 3'b100;
        chk("rej_seed_ready", 32'(seed_ready), 32'd1);
        step();
        seed_valid = 1'b0;
        chk("rej_seed_err",   32'(seed_err), 32'd1);
        chk("rej_busy",       32'(busy),     32'd0);
        chk("rej_lfsr_ena",   32'(lfsr_ena), 32'd0);
        step();
        chk("rej_err_pulse",  32'(seed_err),   32'd0);
        chk("rej_still_idle", 32'(seed_ready), 32'd1);
        chk("rej_ena_low",    32'(lfsr_ena),   32'd0);

        // Seed 101 with req held: LOAD drives 1,0,1 then GEN
        seed_valid = 1'b1;
        seed_data  = 3'b101;
        req        = 1'b1;
        step();
        seed_valid = 1'b0;
        chk("load_busy",       32'(busy),       32'd1);
        chk("load_ena",        32'(lfsr_ena),   32'd0);
        chk("load_seed_ready", 32'(seed_ready), 32'd0);
        chk("load_bit0",       32'(lfsr_seed),  32'd1);
        step();
        chk("load_bit1",       32'(lfsr_seed),  32'd0);
        step();
        chk("load_bit2",       32'(lfsr_seed),  32'd1);
        step();
        chk("gen_ena",         32'(lfsr_ena),   32'd1);
        chk("gen_busy",        32'(busy),       32'd1);
        wait_valid(n);
        chk("word1_latency",   32'(n),          32'd8);
        chk("word1_data",      32'(word_data),  32'hB6);

        // Backpressure in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid",      32'(word_valid), 32'd1);
            chk("bp_data",       32'(word_data),  32'hB6);
            chk("bp_seed_ready", 32'(seed_ready), 32'd0);
        end
        word_ready = 1'b1;
        req        = 1'b0;
        step();
        word_ready = 1'b0;
        chk("bp_acc_valid",      32'(word_valid), 32'd0);
        chk("bp_acc_busy",       32'(busy),       32'd0);
        chk("bp_acc_seed_ready", 32'(seed_ready), 32'd1);
        chk("bp_acc_ena",        32'(lfsr_ena),   32'd1);
        step();
        chk("seeded_idle_busy",  32'(busy),       32'd0);

        // Reseed priority: seed_valid and req together in SEEDED
        seed_valid = 1'b1;
        seed_data  = 3'b101;
        req        = 1'b1;
        word_ready = 1'b1;
        step();
        seed_valid = 1'b0;
        chk("prio_busy",  32'(busy),      32'd1);
        chk("prio_ena",   32'(lfsr_ena),  32'd0);
        chk("prio_bit0",  32'(lfsr_seed), 32'd1);
        repeat (3) step();
        chk("prio_gen_ena", 32'(lfsr_ena), 32'd1);

        // Continuous stream with word_ready held high
        wait_valid(n);
        chk("stream_w1_latency", 32'(n),         32'd8);
        chk("stream_w1_data",    32'(word_data), 32'hB6);
        step();
        chk("stream_hold_1cyc",  32'(word_valid), 32'd0);
        wait_valid(n);
        chk("stream_w2_latency", 32'(n + 1),     32'd9);
        chk("stream_w2_data",    32'(word_data), 32'hB6);
        req = 1'b0;
        step();
        word_ready = 1'b0;
        chk("stream_end_busy",  32'(busy),       32'd0);
        chk("stream_end_valid", 32'(word_valid), 32'd0);

        // Reset in the middle of GEN
        req = 1'b1;
        repeat (4) step();
        chk("midgen_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        chk("mrst_valid",      32'(word_valid), 32'd0);
        chk("mrst_busy",       32'(busy),       32'd0);
        chk("mrst_ena",        32'(lfsr_ena),   32'd0);
        chk("mrst_seed_ready", 32'(seed_ready), 32'd1);
        chk("mrst_word_data",  32'(word_data),  32'd0);
        rst      = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy !== 1'b0 || word_valid !== 1'b0 || lfsr_ena !== 1'b0) saw_busy = 1'b1;
        end
        chk("mrst_no_gen", 32'(saw_busy), 32'd0);
        req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_sequencer.md
# lfsr_sequencer

Controller for the 3-stage seeded LFSR core (mux-selected seed input, taps d1^d2, registered serial output). It drives the core's `ena`/`seed` pins to load a 3-bit seed serially, then lets the core free-run. It deserializes the core's output bit stream into WORD_W-bit random words, delivered over a valid/ready handshake. It sits between the core and any consumer of random words; the core itself is instantiated beside it, not inside it.

## Interface
- WORD_W, 8, bits per output word (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- seed_valid  in  1  seed offer
- seed_ready  out  1  seed accepted when valid&ready at a clk edge
- seed_data  in  3  seed; bit 2 shifted into the core first
- seed_err  out  1  one-cycle pulse: seed rejected (would lock core)
- req  in  1  level; request words
- word_valid  out  1  word_data valid
- word_ready  in  1  consumer accepts
- word_data  out  WORD_W  first sampled bit in MSB
- lfsr_ena  out  1  to core `ena` (0 selects seed path)
- lfsr_seed  out  1  to core `seed`
- lfsr_out  in  1  from core `out`
- busy  out  1  high in LOAD, GEN, HOLD

## Operation
- States: IDLE (unseeded), LOAD, SEEDED, GEN, HOLD.
- Outputs by state:
  - IDLE: lfsr_ena=0, lfsr_seed=0, which flushes the core to zeros.
  - LOAD: lfsr_ena=0, lfsr_seed=seed bit selected by the 2-bit counter.
  - All other states: lfsr_ena=1; the core free-runs, since it has no hold mode.
- seed_ready=1 only in IDLE and SEEDED.
- Seed accept (valid&ready):
  - If seed_data[1:0]==2'b00, the seed is rejected. After load these bits become d2:d1, and an all-zero d2:d1 is the lock state. seed_err pulses the following cycle and the state is unchanged.
  - Otherwise, latch the seed, clear the counter, go to LOAD.
- LOAD: 3 cycles, driving seed[2], seed[1], seed[0] in order. The core then holds d1=seed[0], d2=seed[1], out=seed[2].
  - At the last LOAD edge, go to GEN if req=1, else to SEEDED.
- SEEDED: seed_valid has priority over req in the same cycle (reseed wins). Otherwise, req=1 goes to GEN.
- GEN: WORD_W cycles. Each edge shifts lfsr_out into the word register LSB, shifting left. After WORD_W edges, go to HOLD.
- HOLD: word_valid=1 and word_data stable until word_ready. On the accept edge, go to GEN if req=1, else to SEEDED.
- seed_valid in LOAD/GEN/HOLD is ignored (seed_ready=0) and no error is raised.
- Reset asserted anywhere, including mid-LOAD or mid-GEN: the state goes to IDLE immediately. All outputs return to reset values and any partial word is discarded. The core must be reseeded after reset.

## Timing
- Reset values: seed_ready=1, seed_err=0, word_valid=0, word_data=0, lfsr_ena=0, lfsr_seed=0, busy=0.
- Seed accept edge to first LOAD cycle: 1 cycle. LOAD occupies exactly 3 cycles.
- GEN entry to word_valid high: WORD_W edges.
- req-to-valid latency from SEEDED: WORD_W+1 cycles.
- Back-to-back words with word_ready held high: one word every WORD_W+1 cycles, with HOLD lasting 1 cycle.
- Outputs are registered; word_valid never depends combinationally on word_ready.

## Structure
- Package `lfsr_seq_pkg`: state enum (IDLE, LOAD, SEEDED, GEN, HOLD), localparam LFSR_LEN=3, LOAD_CYCLES=3.
- Natural sub-module: `bit_deser` (WORD_W shift register plus bit counter, with a done flag).
- FSM and seed mux stay in the top-level block.

## Test plan
- Reset mid-operation:
  - Stimulus: rst low during GEN.
  - Response: next cycle word_valid=0, busy=0, lfsr_ena=0, seed_ready=1; a subsequent req with no seed causes no GEN.
- Seed, then immediate generation:
  - Stimulus: seed 3'b101 with req=1 throughout, WORD_W=8.
  - Response: lfsr_seed drives 1,0,1 over LOAD; word_valid rises 8 cycles after LOAD ends with word_data=8'hB6.
- Continuous stream:
  - Stimulus: previous case with word_ready=1.
  - Response: second word is 8'hB6, 9 cycles after the first (core period 3 divides 9).
- Backpressure:
  - Stimulus: word_ready low for 5 cycles in HOLD.
  - Response: word_valid stays 1, word_data is constant, seed_ready=0; accept on cycle 6 then req=0 returns to SEEDED.
- Rejected seed:
  - Stimulus: seed 3'b100 offered in IDLE.
  - Response: seed_ready=1, seed_err pulses once, state stays IDLE, lfsr_ena stays 0.
- Reseed priority:
  - Stimulus: in SEEDED, seed_valid and req both high in the same cycle.
  - Response: LOAD entered (busy=1, lfsr_ena=0) and GEN is not entered that cycle.
